// File: rtl/exception_unit.sv
// Precise-exception and ERET sequencer for the 5-stage MIPS pipeline.
// Holds the CP0 registers (Status, Cause, EPC, BadVAddr) and the kernel/user mode bit.
module exception_unit #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] HANDLER_ADDR = 32'h80000180,
    parameter logic        RESET_MODE   = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            exc_ri,
    input  logic            exc_sys,
    input  logic            exc_ret,
    input  logic            exc_ovf,
    input  logic            exc_addr,
    input  logic [XLEN-1:0] exc_badaddr,
    input  logic [XLEN-1:0] exc_pc,
    input  logic            irq,
    input  logic            mem_busy,
    input  logic            cowrite,
    input  logic [4:0]      co_idx,
    input  logic [XLEN-1:0] co_wdata,
    output logic [XLEN-1:0] co_rdata,
    output logic            cpu_mode,
    output logic            flush,
    output logic            pc_load,
    output logic [XLEN-1:0] pc_target,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        FLUSH    = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    localparam logic [4:0] IDX_BADVADDR = 5'd8;
    localparam logic [4:0] IDX_STATUS   = 5'd12;
    localparam logic [4:0] IDX_CAUSE    = 5'd13;
    localparam logic [4:0] IDX_EPC      = 5'd14;

    state_t          state_q;
    logic            flush_q;
    logic            pc_load_q;
    logic            busy_q;
    logic [XLEN-1:0] pc_target_q;
    logic            cpu_mode_q;
    logic            eret_q;
    logic            status_ie_q;
    logic [4:0]      exc_code_q;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] badvaddr_q;

    logic            is_idle_s;
    logic            irq_take_s;
    logic            exc_take_s;
    logic            eret_take_s;
    logic            mtc0_en_s;
    logic [4:0]      code_s;

    // Event arbitration: pick the highest-priority source and gate MTC0 behind it.
    always_comb begin
        is_idle_s   = (state_q == IDLE);
        irq_take_s  = irq & status_ie_q & ~cpu_mode_q;
        exc_take_s  = is_idle_s & (exc_addr | exc_ovf | exc_ri | exc_sys | irq_take_s);
        eret_take_s = is_idle_s & ~exc_take_s & exc_ret & cpu_mode_q;
        mtc0_en_s   = cowrite & is_idle_s & cpu_mode_q & ~exc_take_s & ~eret_take_s;
        if (exc_addr) begin
            code_s = 5'd4;
        end else if (exc_ovf) begin
            code_s = 5'd12;
        end else if (exc_ri) begin
            code_s = 5'd10;
        end else if (exc_sys) begin
            code_s = 5'd8;
        end else begin
            code_s = 5'd0;
        end
    end

    // MFC0 read mux.
    always_comb begin
        case (co_idx)
            IDX_BADVADDR: co_rdata = badvaddr_q;
            IDX_STATUS:   co_rdata = {{(XLEN-1){1'b0}}, status_ie_q};
            IDX_CAUSE:    co_rdata = {{(XLEN-7){1'b0}}, exc_code_q, 2'b00};
            IDX_EPC:      co_rdata = epc_q;
            default:      co_rdata = {XLEN{1'b0}};
        endcase
    end

    // Sequencer FSM with registered outputs, plus CP0 register updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            flush_q     <= 1'b0;
            pc_load_q   <= 1'b0;
            busy_q      <= 1'b0;
            pc_target_q <= {XLEN{1'b0}};
            cpu_mode_q  <= RESET_MODE;
            eret_q      <= 1'b0;
            status_ie_q <= 1'b0;
            exc_code_q  <= 5'd0;
            epc_q       <= {XLEN{1'b0}};
            badvaddr_q  <= {XLEN{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (exc_take_s || eret_take_s) begin
                        state_q <= mem_busy ? DRAIN : FLUSH;
                        flush_q <= ~mem_busy;
                        busy_q  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!mem_busy) begin
                        state_q <= FLUSH;
                        flush_q <= 1'b1;
                    end
                end
                FLUSH: begin
                    state_q   <= REDIRECT;
                    flush_q   <= 1'b1;
                    pc_load_q <= 1'b1;
                end
                REDIRECT: begin
                    state_q   <= IDLE;
                    flush_q   <= 1'b0;
                    pc_load_q <= 1'b0;
                    busy_q    <= 1'b0;
                    // ERET drops privilege only once the redirect is committed.
                    if (eret_q) begin
                        cpu_mode_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    flush_q   <= 1'b0;
                    pc_load_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase

            if (exc_take_s) begin
                epc_q       <= exc_pc;
                exc_code_q  <= code_s;
                cpu_mode_q  <= 1'b1;
                pc_target_q <= HANDLER_ADDR[XLEN-1:0];
                eret_q      <= 1'b0;
                if (exc_addr) begin
                    badvaddr_q <= exc_badaddr;
                end
            end else if (eret_take_s) begin
                pc_target_q <= epc_q;
                eret_q      <= 1'b1;
            end else if (mtc0_en_s) begin
                case (co_idx)
                    IDX_BADVADDR: badvaddr_q  <= co_wdata;
                    IDX_STATUS:   status_ie_q <= co_wdata[0];
                    IDX_CAUSE:    exc_code_q  <= co_wdata[6:2];
                    IDX_EPC:      epc_q       <= co_wdata;
                    default:      epc_q       <= epc_q;
                endcase
            end
        end
    end

    assign flush     = flush_q;
    assign pc_load   = pc_load_q;
    assign busy      = busy_q;
    assign pc_target = pc_target_q;
    assign cpu_mode  = cpu_mode_q;

endmodule

// File: tb/tb_exception_unit.sv
// Directed, table-driven bench for exception_unit.
module tb_exception_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_ri, exc_sys, exc_ret, exc_ovf, exc_addr;
    logic [31:0] exc_badaddr, exc_pc;
    logic        irq, mem_busy, cowrite;
    logic [4:0]  co_idx;
    logic [31:0] co_wdata, co_rdata;
    logic        cpu_mode, flush, pc_load, busy;
    logic [31:0] pc_target;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] HANDLER = 32'h80000180;

    exception_unit dut (
        .clk(clk), .reset(reset),
        .exc_ri(exc_ri), .exc_sys(exc_sys), .exc_ret(exc_ret),
        .exc_ovf(exc_ovf), .exc_addr(exc_addr),
        .exc_badaddr(exc_badaddr), .exc_pc(exc_pc),
        .irq(irq), .mem_busy(mem_busy), .cowrite(cowrite),
        .co_idx(co_idx), .co_wdata(co_wdata), .co_rdata(co_rdata),
        .cpu_mode(cpu_mode), .flush(flush), .pc_load(pc_load),
        .pc_target(pc_target), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        addr, ovf, ri, sys, ret;
        logic [31:0] badaddr, pc, exp_cause, exp_badv;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        exc_ri = 1'b0; exc_sys = 1'b0; exc_ret = 1'b0; exc_ovf = 1'b0; exc_addr = 1'b0;
        irq = 1'b0; cowrite = 1'b0;
    endtask

    task automatic rd(input string name, input logic [4:0] idx, input logic [31:0] exp);
        co_idx = idx;
        #1;
        chk(name, co_rdata, exp);
    endtask

    task automatic mtc0(input logic [4:0] idx, input logic [31:0] data);
        cowrite = 1'b1; co_idx = idx; co_wdata = data;
        tick();
        cowrite = 1'b0;
    endtask

    // Call right after the accept edge with mem_busy=0: checks FLUSH, REDIRECT, IDLE.
    task automatic tail(input string name, input logic [31:0] exp_target, input logic exp_mode_after);
        chk({name, "_n1_flush"}, {31'd0, flush}, 32'd1);
        chk({name, "_n1_pcload"}, {31'd0, pc_load}, 32'd0);
        chk({name, "_n1_busy"}, {31'd0, busy}, 32'd1);
        clear_inputs();
        tick();
        chk({name, "_n2_pcload"}, {31'd0, pc_load}, 32'd1);
        chk({name, "_n2_flush"}, {31'd0, flush}, 32'd1);
        chk({name, "_n2_target"}, pc_target, exp_target);
        tick();
        chk({name, "_n3_idle"}, {29'd0, busy, flush, pc_load}, 32'd0);
        chk({name, "_n3_mode"}, {31'd0, cpu_mode}, {31'd0, exp_mode_after});
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10010003, 32'h00400300, 32'h10, 32'h10010003};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h00400304, 32'h30, 32'h10010003};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h00400308, 32'h28, 32'h10010003};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0040030C, 32'h20, 32'h10010003};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h00400310, 32'h20, 32'h10010003};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000002, 32'h00400314, 32'h10, 32'h00000002};

        clear_inputs();
        exc_badaddr = 32'd0; exc_pc = 32'd0; mem_busy = 1'b0; co_idx = 5'd0; co_wdata = 32'd0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_outputs", {29'd0, busy, flush, pc_load}, 32'd0);
        chk("rst_target", pc_target, 32'd0);
        chk("rst_mode", {31'd0, cpu_mode}, 32'd1);
        rd("rst_badv", 5'd8, 32'd0);
        rd("rst_status", 5'd12, 32'd0);
        rd("rst_cause", 5'd13, 32'd0);
        rd("rst_epc", 5'd14, 32'd0);

        // Kernel MTC0 EPC, then ERET back to user.
        mtc0(5'd14, 32'h00400020);
        rd("eret_epc_before", 5'd14, 32'h00400020);
        exc_ret = 1'b1;
        tick();
        chk("eret_mode_flush", {31'd0, cpu_mode}, 32'd1);
        tail("eret", 32'h00400020, 1'b0);
        rd("eret_epc_after", 5'd14, 32'h00400020);

        // User mode: ERET ignored, MTC0 dropped, irq masked.
        exc_ret = 1'b1;
        tick();
        chk("user_eret_ignored", {30'd0, busy, flush}, 32'd0);
        clear_inputs();
        mtc0(5'd12, 32'h1);
        rd("user_mtc0_dropped", 5'd12, 32'd0);
        irq = 1'b1;
        tick();
        chk("irq_masked", {30'd0, busy, flush}, 32'd0);
        clear_inputs();

        // Syscall from user mode.
        exc_sys = 1'b1; exc_pc = 32'h00400010;
        tick();
        chk("sys_mode", {31'd0, cpu_mode}, 32'd1);
        tail("sys", HANDLER, 1'b1);
        rd("sys_epc", 5'd14, 32'h00400010);
        rd("sys_cause", 5'd13, 32'h20);

        // Enable interrupts, return to user, take irq.
        mtc0(5'd12, 32'hFFFFFFFF);
        rd("status_ie", 5'd12, 32'd1);
        mtc0(5'd14, 32'h00400100);
        exc_ret = 1'b1;
        tick();
        tail("eret2", 32'h00400100, 1'b0);
        irq = 1'b1; exc_pc = 32'h00400104;
        tick();
        tail("irq", HANDLER, 1'b1);
        rd("irq_cause", 5'd13, 32'd0);
        rd("irq_epc", 5'd14, 32'h00400104);

        // Priority table, back-to-back in kernel mode.
        for (int i = 0; i < 6; i++) begin
            exc_addr = vecs[i].addr; exc_ovf = vecs[i].ovf; exc_ri = vecs[i].ri;
            exc_sys = vecs[i].sys; exc_ret = vecs[i].ret;
            exc_badaddr = vecs[i].badaddr; exc_pc = vecs[i].pc;
            tick();
            tail($sformatf("vec%0d", i), HANDLER, 1'b1);
            rd($sformatf("vec%0d_cause", i), 5'd13, vecs[i].exp_cause);
            rd($sformatf("vec%0d_badv", i), 5'd8, vecs[i].exp_badv);
            rd($sformatf("vec%0d_epc", i), 5'd14, vecs[i].pc);
        end

        // Event beats a simultaneous MTC0.
        exc_sys = 1'b1; exc_pc = 32'h00400200;
        cowrite = 1'b1; co_idx = 5'd14; co_wdata = 32'h12345678;
        tick();
        tail("cowrite_lost", HANDLER, 1'b1);
        rd("cowrite_lost_epc", 5'd14, 32'h00400200);

        // Drain: three DRAIN cycles, then FLUSH/REDIRECT.
        exc_ri = 1'b1; exc_pc = 32'h00400400; mem_busy = 1'b1;
        tick();
        exc_ri = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("drain%0d_busy", d), {31'd0, busy}, 32'd1);
            chk($sformatf("drain%0d_noflush", d), {30'd0, flush, pc_load}, 32'd0);
            if (d == 2) mem_busy = 1'b0;
            tick();
        end
        chk("drain_flush", {31'd0, flush}, 32'd1);
        chk("drain_nopcload", {31'd0, pc_load}, 32'd0);
        tick();
        chk("drain_pcload", {31'd0, pc_load}, 32'd1);
        tick();
        chk("drain_idle", {29'd0, busy, flush, pc_load}, 32'd0);
        rd("drain_cause", 5'd13, 32'h28);

        // Reset while in DRAIN.
        exc_sys = 1'b1; exc_pc = 32'h00400500; mem_busy = 1'b1;
        tick();
        exc_sys = 1'b0;
        chk("rdrain_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0; mem_busy = 1'b0;
        chk("rdrain_outputs", {29'd0, busy, flush, pc_load}, 32'd0);
        chk("rdrain_mode", {31'd0, cpu_mode}, 32'd1);
        chk("rdrain_target", pc_target, 32'd0);
        rd("rdrain_badv", 5'd8, 32'd0);
        rd("rdrain_status", 5'd12, 32'd0);
        rd("rdrain_cause", 5'd13, 32'd0);
        rd("rdrain_epc", 5'd14, 32'd0);
        tick();
        chk("rdrain_dropped", {30'd0, busy, flush}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
